// File: rtl/tmds_serializer_10to1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmds_serializer_10to1_pkg
// Purpose  : Shared constants for the 10:1 TMDS serializer slice.
// Contents : WORD_BITS - parallel symbol width (one TMDS symbol)
//            CNT_BITS  - width of the bit-position counter
// Revision : 1.0 - initial release
// ============================================================================
package tmds_serializer_10to1_pkg;

    localparam int WORD_BITS = 10;
    localparam int CNT_BITS  = $clog2(WORD_BITS);

endpackage : tmds_serializer_10to1_pkg
`default_nettype wire

// File: rtl/tmds_serializer_10to1_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : bit_counter_mod_n
// Purpose  : Free-running counter wrapping 0..N-1 with a load strobe that is
//            high while the count is zero (the serializer's load edge).
// Ports    : clk   in  1  counter clock (rising edge)
//            rst_n in  1  synchronous active-low reset, clears count to 0
//            count out W  current bit position
//            load  out 1  high when count == 0
// Revision : 1.0 - initial release
// ============================================================================
module bit_counter_mod_n #(
    parameter int N = 10,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] count,
    output logic         load
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == W'(N - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Decoded from the register, so the load decision for an edge is made
    // from the count that edge sees.
    assign load = (count == '0);

endmodule : bit_counter_mod_n
`default_nettype wire

// File: rtl/tmds_serializer_10to1.sv
`default_nettype none
// ============================================================================
// Module   : tmds_serializer_10to1
// Purpose  : 10:1 parallel-to-serial converter for one TMDS channel. Runs in
//            the bit clock domain and emits one bit per clock, LSB first,
//            with back-to-back words and no idle bits.
// Ports    : i_clk        in  1      serial bit clock
//            i_rst_n      in  1      synchronous active-low reset
//            i_data       in  WIDTH  parallel word, sampled on load edges only
//            o_data       out 1      registered serial bit
//            o_word_start out 1      registered strobe, high with bit 0
// Revision : 1.0 - initial release
// ============================================================================
module tmds_serializer_10to1
    import tmds_serializer_10to1_pkg::*;
#(
    parameter int   WIDTH     = WORD_BITS,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_data,
    output logic             o_word_start
);

    localparam int CW = (WIDTH == WORD_BITS) ? CNT_BITS : $clog2(WIDTH);

    logic [CW-1:0]    bit_cnt;
    logic             load;
    logic [WIDTH-1:0] sreg;

    bit_counter_mod_n #(
        .N (WIDTH),
        .W (CW)
    ) u_bit_counter (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .count (bit_cnt),
        .load  (load)
    );

    // Bit 0 goes straight to the output flop on the load edge; the shift
    // register only holds the remaining bits, so there is no gap between
    // the last bit of one word and the first bit of the next.
    // The reset branch never reads i_data, so X on the bus during reset
    // cannot reach any register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sreg         <= '0;
            o_data       <= RESET_BIT;
            o_word_start <= 1'b0;
        end else if (load) begin
            o_data       <= i_data[0];
            sreg         <= i_data >> 1;
            o_word_start <= 1'b1;
        end else begin
            o_data       <= sreg[0];
            sreg         <= sreg >> 1;
            o_word_start <= 1'b0;
        end
    end

endmodule : tmds_serializer_10to1
`default_nettype wire

// File: tb/tb_tmds_serializer_10to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_serializer_10to1
// Purpose  : Self-checking bench for tmds_serializer_10to1. Three instances
//            share clock and reset; instance 0 carries the directed word
//            sequence, instances 1 and 2 hold fixed words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_serializer_10to1;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data0, data1, data2;
    logic         sd0, sd1, sd2;
    logic         ws0, ws1, ws2;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle output: {ws2,d2,ws1,d1,ws0,d0}
    logic [5:0] exp_q[$];
    int         pos = 0;     // bench's own word-position tracker

    always #5 clk = ~clk;

    tmds_serializer_10to1 #(.WIDTH(W), .RESET_BIT(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data0),
        .o_data(sd0), .o_word_start(ws0));
    tmds_serializer_10to1 #(.WIDTH(W), .RESET_BIT(1'b0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data1),
        .o_data(sd1), .o_word_start(ws1));
    tmds_serializer_10to1 #(.WIDTH(W), .RESET_BIT(1'b0)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data2),
        .o_data(sd2), .o_word_start(ws2));

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed={ws,d}=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One clock: scoreboard push at the edge from what was driven, then
    // pop and compare 1 time unit later.
    task automatic tick(input string tag);
        logic [5:0] e;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            exp_q.push_back(6'b000000);
            pos = 0;
        end else begin
            if (pos == 0) begin
                for (int k = 0; k < W; k++) begin
                    e = {(k == 0), data2[k], (k == 0), data1[k], (k == 0), data0[k]};
                    exp_q.push_back(e);
                end
            end
            pos = (pos + 1) % W;
        end
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=%b expected=entry", tag, {ws0, sd0});
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_ch0"}, {ws0, sd0}, e[1:0]);
            chk({tag, "_ch1"}, {ws1, sd1}, e[3:2]);
            chk({tag, "_ch2"}, {ws2, sd2}, e[5:4]);
        end
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        // Reset held with all-ones data: outputs must stay 0
        rst_n = 1'b0;
        data0 = 10'b1111111111;
        data1 = 10'b1111111111;
        data2 = 10'b1111111111;
        ticks(3, "reset");

        // Release; channel 0 carries 0110100110, repeated twice
        data0 = 10'b0110100110;
        data1 = 10'b1001011001;
        data2 = 10'b1100000010;
        rst_n = 1'b1;
        ticks(20, "word_a");

        // Channel 0 switches to the other two words at word boundaries
        data0 = 10'b1001011001;
        ticks(10, "word_b");
        data0 = 10'b1100000010;
        ticks(10, "word_c");

        // Mid-word change at bit position 4 must not disturb current word
        data0 = 10'b0110100110;
        ticks(4, "switch_pre");
        data0 = 10'b1001011001;
        ticks(16, "switch_post");

        // Reset at bit position 5 for one edge, then a fresh word
        ticks(5, "pre_rst");
        rst_n = 1'b0;
        ticks(1, "mid_rst");
        rst_n = 1'b1;
        data0 = 10'b0110100110;
        ticks(21, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tmds_serializer_10to1
`default_nettype wire
